pll_lock_monitor: RTL and testbench

//  Consumer side of the iCE40 PLL: supervises the PLL LOCK output and produces a clean, glitch-free

---
 rtl/pll_lock_monitor_pkg.sv | 13 +
 rtl/pll_lock_monitor_sync2.sv | 25 ++
 rtl/pll_lock_monitor.sv | 161 ++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_monitor_pkg.sv
// Shared definitions for the PLL lock monitor: FSM state encoding and state width.
package pll_mon_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RUN       = 2'd2,
        ST_HOLD      = 2'd3
    } state_e;

endpackage

// File: rtl/pll_lock_monitor_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal; resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock supervisor on the reference clock: synchronizes LOCK, qualifies it for
// STABLE_CYCLES, forces downstream reset on loss of lock and counts loss events.
// Optional feature macro: PLL_LOCK_TIMEOUT_EN adds a lock-acquisition timeout that
// pulses pll_resetb low for HOLD_CYCLES and sets the sticky timeout_err flag.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1200,
    parameter int HOLD_CYCLES    = 16,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               pll_locked_async,
    input  logic               clr,
    output logic               sys_rst_n,
    output logic               ready,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   loss_count,
    output logic               loss_err,
    output logic               pll_resetb,
    output logic               timeout_err
);

    localparam int MAX_SH = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
    localparam int CTR_W  = $clog2(MAX_C + 1);

    localparam logic [CTR_W-1:0] STABLE_LAST = CTR_W'(STABLE_CYCLES - 1);
    localparam logic [CTR_W-1:0] HOLD_LAST   = CTR_W'(HOLD_CYCLES - 1);

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0] loss_count_q, loss_count_d;
    logic             loss_err_q, loss_err_d;
    logic             sys_rst_n_q, ready_q;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (nrst),
        .d_i   (pll_locked_async),
        .q_o   (locked_s)
    );

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam logic [CTR_W-1:0] TMO_LAST = CTR_W'(TIMEOUT_CYCLES - 1);

    logic [CTR_W-1:0] tmo_q, tmo_d;
    logic             pll_resetb_q, pll_resetb_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // Next-state decode, loss statistics and (optionally) the acquisition timeout.
    always_comb begin
        state_d      = state_q;
        ctr_d        = ctr_q;
        loss_count_d = clr ? '0 : loss_count_q;
        loss_err_d   = clr ? 1'b0 : loss_err_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABILIZE;
                    ctr_d   = '0;
                end
            end
            ST_STABILIZE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    ctr_d = ctr_q + CTR_W'(1);
                    if (ctr_q == STABLE_LAST) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d    = ST_HOLD;
                    ctr_d      = '0;
                    // A loss event overrides a coincident clear so it is never dropped.
                    loss_err_d = 1'b1;
                    if (loss_count_d != '1) loss_count_d = loss_count_d + CNT_W'(1);
                end
            end
            default: begin
                ctr_d = ctr_q + CTR_W'(1);
                if (ctr_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
            end
        endcase

`ifdef PLL_LOCK_TIMEOUT_EN
        tmo_d         = tmo_q;
        timeout_err_d = clr ? 1'b0 : timeout_err_q;
        // pll_resetb stays low only while remaining in a timeout-initiated HOLD.
        pll_resetb_d  = (state_q == ST_HOLD && state_d == ST_HOLD) ? pll_resetb_q : 1'b1;

        if (state_q == ST_WAIT_LOCK || state_q == ST_STABILIZE) begin
            // Timeout wins over a same-cycle qualification into RUN.
            if (tmo_q == TMO_LAST) begin
                state_d       = ST_HOLD;
                ctr_d         = '0;
                timeout_err_d = 1'b1;
                pll_resetb_d  = 1'b0;
            end else begin
                tmo_d = tmo_q + CTR_W'(1);
            end
        end else if (state_q == ST_HOLD && state_d == ST_WAIT_LOCK) begin
            // Only a completed HOLD restarts the budget; chattering lock keeps accumulating.
            tmo_d = '0;
        end
`endif
    end

    // State, counter and registered output flops.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_WAIT_LOCK;
            ctr_q        <= '0;
            loss_count_q <= '0;
            loss_err_q   <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            loss_count_q <= loss_count_d;
            loss_err_q   <= loss_err_d;
            sys_rst_n_q  <= (state_d == ST_RUN);
            ready_q      <= (state_d == ST_RUN);
        end
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    // Timeout counter, PLL reset drive and sticky timeout flag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tmo_q         <= '0;
            pll_resetb_q  <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            pll_resetb_q  <= pll_resetb_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign pll_resetb  = pll_resetb_q;
    assign timeout_err = timeout_err_q;
`else
    assign pll_resetb  = 1'b1;
    assign timeout_err = 1'b0;
`endif

    assign state      = state_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign ready      = ready_q;
    assign loss_count = loss_count_q;
    assign loss_err   = loss_err_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: vector table, hand-written corner
// sequences and randomized lock activity against a cycle-level reference model.
module tb_pll_lock_monitor;

    localparam int STABLE  = 8;
    localparam int HOLD    = 4;
    localparam int CW      = 2;
    localparam int TIMEOUT = 50;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          lock_i = 1'b0;
    logic          clr_i = 1'b0;
    logic          sys_rst_n, ready, loss_err, pll_resetb, timeout_err;
    logic [1:0]    state;
    logic [CW-1:0] loss_count;

    int total = 0;
    int bad   = 0;

    pll_lock_monitor #(
        .STABLE_CYCLES  (STABLE),
        .HOLD_CYCLES    (HOLD),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .pll_locked_async (lock_i),
        .clr              (clr_i),
        .sys_rst_n        (sys_rst_n),
        .ready            (ready),
        .state            (state),
        .loss_count       (loss_count),
        .loss_err         (loss_err),
        .pll_resetb       (pll_resetb),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Lock is qualified by counting consecutive synchronized-high cycles (qual);
    // running means downstream is released; hold_left counts remaining reset cycles.
    int m_s1, m_s2, m_qual, m_hold, m_tmo, m_cnt;
    bit m_run, m_tmo_hold, m_err, m_terr;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_qual = 0; m_hold = 0; m_tmo = 0; m_cnt = 0;
        m_run = 0; m_tmo_hold = 0; m_err = 0; m_terr = 0;
    endtask

    task automatic model_edge(input bit l, input bit c);
        int ls;
        bit evt, tevt;
        ls = m_s2; m_s2 = m_s1; m_s1 = int'(l);
        evt = 0; tevt = 0;
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                m_tmo_hold = 0;
                m_tmo = 0;
            end
        end else if (m_run) begin
            if (ls == 0) begin
                m_run = 0; m_hold = HOLD; evt = 1;
            end
        end else begin
            bit timed_out;
            timed_out = 0;
`ifdef PLL_LOCK_TIMEOUT_EN
            if (m_tmo == TIMEOUT - 1) begin
                timed_out = 1;
                m_hold = HOLD; m_tmo_hold = 1; m_qual = 0; tevt = 1;
            end else begin
                m_tmo++;
            end
`endif
            if (!timed_out) begin
                if (ls != 0) m_qual++; else m_qual = 0;
                if (m_qual == STABLE + 1) begin
                    m_run = 1; m_qual = 0;
                end
            end
        end
        if (c) begin
            m_cnt = 0; m_err = 0; m_terr = 0;
        end
        if (evt) begin
            m_err = 1;
            if (m_cnt < CMAX) m_cnt++;
        end
        if (tevt) m_terr = 1;
    endtask

    function automatic int m_state();
        if (m_hold > 0) return 3;
        if (m_run) return 2;
        if (m_qual > 0) return 1;
        return 0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_state", int'(state), m_state());
        chk("m_sys_rst_n", int'(sys_rst_n), int'(m_run));
        chk("m_ready", int'(ready), int'(m_run));
        chk("m_loss_count", int'(loss_count), m_cnt);
        chk("m_loss_err", int'(loss_err), int'(m_err));
        chk("m_pll_resetb", int'(pll_resetb), int'(!(m_hold > 0 && m_tmo_hold)));
        chk("m_timeout_err", int'(timeout_err), int'(m_terr));
    endtask

    // One clock: drive inputs, advance DUT and model, compare 1 time unit later.
    task automatic step(input bit l, input bit c);
        lock_i = l;
        clr_i  = c;
        @(posedge clk);
        model_edge(l, c);
        #1;
        check_model();
        clr_i = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must respond at once.
    task automatic do_reset(input string tag);
        #2;
        nrst = 1'b0;
        #1;
        chk({tag, "_rst_state"}, int'(state), 0);
        chk({tag, "_rst_sys_rst_n"}, int'(sys_rst_n), 0);
        chk({tag, "_rst_ready"}, int'(ready), 0);
        chk({tag, "_rst_loss_count"}, int'(loss_count), 0);
        chk({tag, "_rst_loss_err"}, int'(loss_err), 0);
        chk({tag, "_rst_pll_resetb"}, int'(pll_resetb), 1);
        chk({tag, "_rst_timeout_err"}, int'(timeout_err), 0);
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    // Keep lock high until ready rises; an expired budget is a failure.
    task automatic wait_ready(input string name, input int budget, output int n);
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk({name, "_ready_reached"}, int'(ready === 1'b1), 1);
    endtask

    typedef struct {
        bit       lock;
        bit       clr;
        int       st;
        int       rstn;
        int       cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int n;
        bit l;

        // Lock rises after reset, release, one-cycle drop, HOLD, re-qualify.
        tbl[0]  = '{1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 0};
        tbl[4]  = '{1, 0, 1, 0, 0};
        tbl[5]  = '{1, 0, 1, 0, 0};
        tbl[6]  = '{1, 0, 1, 0, 0};
        tbl[7]  = '{1, 0, 1, 0, 0};
        tbl[8]  = '{1, 0, 1, 0, 0};
        tbl[9]  = '{1, 0, 1, 0, 0};
        tbl[10] = '{1, 0, 2, 1, 0};
        tbl[11] = '{1, 0, 2, 1, 0};
        tbl[12] = '{0, 0, 2, 1, 0};
        tbl[13] = '{1, 0, 2, 1, 0};
        tbl[14] = '{1, 0, 3, 0, 1};
        tbl[15] = '{1, 0, 3, 0, 1};
        tbl[16] = '{1, 0, 3, 0, 1};
        tbl[17] = '{1, 0, 3, 0, 1};
        tbl[18] = '{1, 0, 0, 0, 1};
        tbl[19] = '{1, 0, 1, 0, 1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset("init");

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].lock, tbl[i].clr);
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
            chk($sformatf("tbl%0d_sys_rst_n", i), int'(sys_rst_n), tbl[i].rstn);
            chk($sformatf("tbl%0d_loss_count", i), int'(loss_count), tbl[i].cnt);
        end

        // Short glitch in the qualification window restarts it.
        do_reset("glitch");
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n = 0;
        while (sys_rst_n !== 1'b1 && n < 30) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("glitch_release_edges", n, 11);
        chk("glitch_loss_count", int'(loss_count), 0);

        // Repeated losses saturate the counter.
        do_reset("sat");
        wait_ready("sat_first", 20, n);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            if (k == 0) begin
                chk("loss_sys_rst_n_low", int'(sys_rst_n), 0);
                chk("loss_state_hold", int'(state), 3);
            end
            wait_ready($sformatf("sat%0d", k), 30, n);
            chk($sformatf("sat%0d_requal_edges", k), n, HOLD + 2 + STABLE - 1);
        end
        chk("sat_loss_count", int'(loss_count), CMAX);
        chk("sat_loss_err", int'(loss_err), 1);

        // clr coincident with a loss event, then clr alone.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("clr_evt_loss_count", int'(loss_count), 1);
        chk("clr_evt_loss_err", int'(loss_err), 1);
        wait_ready("clr_alone", 30, n);
        step(1'b1, 1'b1);
        chk("clr_alone_loss_count", int'(loss_count), 0);
        chk("clr_alone_loss_err", int'(loss_err), 0);

        // Asynchronous reset mid-STABILIZE and mid-RUN.
        do_reset("pre_stab");
        repeat (5) step(1'b1, 1'b0);
        chk("mid_stab_state", int'(state), 1);
        do_reset("mid_stab");
        wait_ready("pre_run", 20, n);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        wait_ready("pre_run2", 30, n);
        do_reset("mid_run");

        // Lock never arrives.
        lock_i = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
        n = 0;
        while (pll_resetb !== 1'b0 && n < 60) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("tmo_edges", n, TIMEOUT);
        chk("tmo_err", int'(timeout_err), 1);
        chk("tmo_state", int'(state), 3);
        n = 0;
        while (pll_resetb === 1'b0 && n < 10) begin
            step(1'b0, 1'b0);
            n++;
        end
        chk("tmo_pulse_len", n, HOLD);
        chk("tmo_err_sticky", int'(timeout_err), 1);
`else
        repeat (60) step(1'b0, 1'b0);
        chk("notmo_pll_resetb", int'(pll_resetb), 1);
        chk("notmo_state", int'(state), 0);
        chk("notmo_err", int'(timeout_err), 0);
`endif

        // Randomized lock activity with occasional clears.
        do_reset("rand");
        l = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 11) == 0) l = ~l;
            step(l, $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
